// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
// Block geometry, FSM state encoding and the last-fill owner encoding.
package cache_arb_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_IDX_W  = 3;
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_word_counter.sv
// Block word counter: synchronous clear, count enable, and a sticky flag
// that sets once the counter steps past the last word of a block.
module word_counter
    import cache_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  wrapped
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count   <= '0;
            wrapped <= 1'b0;
        end else if (en) begin
            count <= count + 1'b1;
            if (count == LAST_WORD) begin
                wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single-ported main memory between I-cache fills, D-cache fills
// and D-cache write-through, and steers returning words to the owning cache.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_miss,
    input  logic [ADDR_W-1:0]     ic_miss_addr,
    input  logic                  dc_miss,
    input  logic [ADDR_W-1:0]     dc_miss_addr,
    input  logic                  dc_wr,
    input  logic [ADDR_W-1:0]     dc_wr_addr,
    input  logic [DATA_W-1:0]     dc_wr_data,
    output logic                  dc_wr_ack,
    output logic                  ic_stall,
    output logic                  dc_stall,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  ic_fill_we,
    output logic                  dc_fill_we,
    output logic                  ic_tag_we,
    output logic                  dc_tag_we,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data_in,
    input  logic [DATA_W-1:0]     mem_data_out,
    input  logic                  mem_data_valid
);

    // rst_n keeps its historical name but is an active-high reset.
    logic rst;
    assign rst = rst_n;

    state_t                  state;
    owner_t                  last_fill;
    logic [ADDR_W-5:0]       base;
    logic [WORD_IDX_W-1:0]   issue_cnt;
    logic [WORD_IDX_W-1:0]   ret_cnt;
    logic                    issue_wrapped;
    logic                    ret_wrapped;
    logic                    filling;
    logic                    cnt_clr;
    logic                    issue_en;
    logic                    ret_en;
    logic                    ret_last;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{ic_miss_addr[3:0], dc_miss_addr[3:0]};

    assign filling  = (state != IDLE);
    assign cnt_clr  = rst || !filling;
    assign issue_en = filling && !issue_wrapped;
    assign ret_en   = filling && mem_data_valid && !ret_wrapped;
    assign ret_last = ret_en && (ret_cnt == LAST_WORD);

    word_counter u_issue_cnt (
        .clk     (clk),
        .clr     (cnt_clr),
        .en      (issue_en),
        .count   (issue_cnt),
        .wrapped (issue_wrapped)
    );

    word_counter u_ret_cnt (
        .clk     (clk),
        .clr     (cnt_clr),
        .en      (ret_en),
        .count   (ret_cnt),
        .wrapped (ret_wrapped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            last_fill <= OWNER_D;
        end else begin
            case (state)
                IDLE: begin
                    // A pending write always takes the IDLE cycle; misses wait.
                    if (!dc_wr) begin
                        if (ic_miss && !(dc_miss && last_fill == OWNER_I)) begin
                            state <= FILL_I;
                            base  <= ic_miss_addr[ADDR_W-1:4];
                        end else if (dc_miss) begin
                            state <= FILL_D;
                            base  <= dc_miss_addr[ADDR_W-1:4];
                        end
                    end
                end
                FILL_I, FILL_D: begin
                    if (ret_last) begin
                        state     <= IDLE;
                        last_fill <= (state == FILL_D) ? OWNER_D : OWNER_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so every pin reads zero in the reset cycle.
    always_comb begin
        dc_wr_ack   = 1'b0;
        ic_stall    = 1'b0;
        dc_stall    = 1'b0;
        fill_data   = '0;
        fill_word   = '0;
        ic_fill_we  = 1'b0;
        dc_fill_we  = 1'b0;
        ic_tag_we   = 1'b0;
        dc_tag_we   = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (!rst) begin
            if (state == IDLE) begin
                if (dc_wr) begin
                    mem_en      = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = dc_wr_addr;
                    mem_data_in = dc_wr_data;
                    dc_wr_ack   = 1'b1;
                end
            end else begin
                if (issue_en) begin
                    mem_en   = 1'b1;
                    mem_addr = {base, issue_cnt, 1'b0};
                end
                if (ret_en) begin
                    fill_data = mem_data_out;
                    fill_word = ret_cnt;
                    if (state == FILL_D) begin
                        dc_fill_we = 1'b1;
                        dc_tag_we  = ret_last;
                    end else begin
                        ic_fill_we = 1'b1;
                        ic_tag_we  = ret_last;
                    end
                end
            end
            ic_stall = ic_miss || (state == FILL_I);
            dc_stall = dc_miss || (state == FILL_D) || (dc_wr && state != IDLE);
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a 4-cycle memory model.
// Stimulus queues expected memory/fill/stall events; a monitor checks them.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_miss, dc_miss, dc_wr;
    logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
    logic        dc_wr_ack, ic_stall, dc_stall;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_ack(dc_wr_ack), .ic_stall(ic_stall), .dc_stall(dc_stall),
        .fill_data(fill_data), .fill_word(fill_word),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .ic_tag_we(ic_tag_we), .dc_tag_we(dc_tag_we),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid)
    );

    typedef struct { int c; logic wr; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
    typedef struct { int c; logic dc; logic [2:0] word; logic [15:0] data; logic tag; } fill_exp_t;
    typedef struct { int c; logic all_zero; logic ic_s; logic dc_s; } snap_t;
    typedef struct { logic [15:0] addr; int due; } rd_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];
    snap_t     snap_q[$];
    rd_t       rd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit gap_mode = 0;
    bit force_valid = 0;

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory model: fixed 4-cycle read latency, optional alternate-cycle returns.
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            mem_data_valid = 1'b0;
            mem_data_out   = '0;
            if (force_valid) begin
                force_valid    = 0;
                mem_data_valid = 1'b1;
                mem_data_out   = 16'h7777;
            end else if (rd_q.size() > 0 && rd_q[0].due <= cyc && (!gap_mode || cyc % 2 == 0)) begin
                rd_t r;
                r = rd_q.pop_front();
                mem_data_valid = 1'b1;
                mem_data_out   = mdat(r.addr);
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            mem_exp_t  me;
            fill_exp_t fe;
            snap_t     se;
            @(negedge clk);
            if (ic_fill_we && dc_fill_we) flag_fail("both fill_we high");
            if (mem_en) begin
                if (!mem_wr) rd_q.push_back(rd_t'{mem_addr, cyc + 4});
                if (mem_q.size() == 0) begin
                    flag_fail("unexpected memory access");
                end else begin
                    me = mem_q.pop_front();
                    chk("mem cycle", 64'(cyc), 64'(me.c));
                    chk("mem_wr", 64'(mem_wr), 64'(me.wr));
                    chk("mem_addr", 64'(mem_addr), 64'(me.addr));
                    chk("mem_data_in", 64'(mem_data_in), 64'(me.data));
                    chk("dc_wr_ack", 64'(dc_wr_ack), 64'(me.wr));
                end
            end else begin
                if (dc_wr_ack) flag_fail("dc_wr_ack without memory write");
                if (mem_addr != 0 || mem_data_in != 0) flag_fail("mem pins nonzero while idle");
            end
            if (ic_fill_we || dc_fill_we) begin
                if (fill_q.size() == 0) begin
                    flag_fail("unexpected fill_we");
                end else begin
                    fe = fill_q.pop_front();
                    if (fe.c >= 0) chk("fill cycle", 64'(cyc), 64'(fe.c));
                    chk("fill owner dc", 64'(dc_fill_we), 64'(fe.dc));
                    chk("fill_word", 64'(fill_word), 64'(fe.word));
                    chk("fill_data", 64'(fill_data), 64'(fe.data));
                    chk("tag_we", 64'({ic_tag_we, dc_tag_we}), fe.tag ? (fe.dc ? 64'd1 : 64'd2) : 64'd0);
                end
            end else if (ic_tag_we || dc_tag_we) begin
                flag_fail("tag_we without fill_we");
            end
            while (snap_q.size() > 0 && snap_q[0].c <= cyc) begin
                se = snap_q.pop_front();
                if (se.all_zero)
                    chk("all outputs zero",
                        {4'h0, dc_wr_ack, ic_stall, dc_stall, fill_data, fill_word, ic_fill_we,
                         dc_fill_we, ic_tag_we, dc_tag_we, mem_en, mem_wr, mem_addr, mem_data_in},
                        64'd0);
                else
                    chk("stalls {ic,dc}", 64'({ic_stall, dc_stall}), 64'({se.ic_s, se.dc_s}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic snap(input int c, input logic z, input logic ics, input logic dcs);
        snap_q.push_back(snap_t'{c, z, ics, dcs});
    endtask

    // Fill decided in IDLE at cycle c0: issues c0+1..c0+8, returns c0+5..c0+12.
    task automatic push_fill(input int c0, input logic d, input logic [15:0] a, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] ad;
            ad = {a[15:4], 3'(k), 1'b0};
            mem_q.push_back(mem_exp_t'{c0 + 1 + k, 1'b0, ad, 16'h0});
            fill_q.push_back(fill_exp_t'{gaps ? -1 : c0 + 5 + k, d, 3'(k), mdat(ad), k == 7});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        rst_n = 1'b1;
        ic_miss = 0; dc_miss = 0; dc_wr = 0;
        ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
        tick(); tick();
        snap(cyc, 1, 0, 0);
        tick();
        rst_n = 1'b0;
        snap(cyc, 1, 0, 0);
        tick();

        // single I-cache fill at 0x1234
        c0 = cyc;
        ic_miss = 1; ic_miss_addr = 16'h1234;
        push_fill(c0, 0, 16'h1234, 0);
        snap(c0, 0, 1, 0);
        snap(c0 + 12, 0, 1, 0);
        wait_until(c0 + 13);
        ic_miss = 0;
        snap(c0 + 13, 0, 0, 0);
        tick(); tick();

        // simultaneous misses after reset: I first, D issues 2 cycles after I tag
        rst_n = 1'b1; tick(); rst_n = 1'b0; tick();
        c0 = cyc;
        ic_miss = 1; ic_miss_addr = 16'h2000;
        dc_miss = 1; dc_miss_addr = 16'h3450;
        push_fill(c0, 0, 16'h2000, 0);
        push_fill(c0 + 13, 1, 16'h3450, 0);
        snap(c0 + 6, 0, 1, 1);
        wait_until(c0 + 13);
        ic_miss = 0;
        snap(c0 + 13, 0, 0, 1);
        wait_until(c0 + 26);
        dc_miss = 0;
        snap(c0 + 26, 0, 0, 0);
        tick();

        // write arriving mid-fill waits for IDLE
        c0 = cyc;
        ic_miss = 1; ic_miss_addr = 16'h4400;
        push_fill(c0, 0, 16'h4400, 0);
        wait_until(c0 + 3);
        dc_wr = 1; dc_wr_addr = 16'h0040; dc_wr_data = 16'hBEEF;
        mem_q.push_back(mem_exp_t'{c0 + 13, 1'b1, 16'h0040, 16'hBEEF});
        snap(c0 + 5, 0, 1, 1);
        wait_until(c0 + 13);
        ic_miss = 0;
        snap(c0 + 13, 0, 0, 0);
        tick();
        dc_wr = 0;
        snap(c0 + 14, 0, 0, 0);
        tick();

        // returns on alternate cycles only
        gap_mode = 1;
        c0 = cyc;
        ic_miss = 1; ic_miss_addr = 16'hABC8;
        push_fill(c0, 0, 16'hABC8, 1);
        for (int i = 0; i < 60 && fill_q.size() > 0; i++) tick();
        if (fill_q.size() > 0) flag_fail("gapped fill did not complete");
        ic_miss = 0;
        gap_mode = 0;
        tick();

        // stray valid in IDLE must be ignored
        force_valid = 1;
        tick(); tick(); tick();

        // reset during cycle 6 of a fill, then a normal D fill
        c0 = cyc;
        ic_miss = 1; ic_miss_addr = 16'h6060;
        push_fill(c0, 0, 16'h6060, 0);
        wait_until(c0 + 6);
        rst_n = 1'b1;
        ic_miss = 0;
        mem_q.delete();
        fill_q.delete();
        snap(c0 + 6, 1, 0, 0);
        tick();
        rst_n = 1'b0;
        snap(c0 + 7, 1, 0, 0);
        wait_until(c0 + 10);
        dc_miss = 1; dc_miss_addr = 16'h8010;
        push_fill(c0 + 10, 1, 16'h8010, 0);
        wait_until(c0 + 23);
        dc_miss = 0;
        tick();

        // write and D miss together: write acked first, fill next cycle
        c0 = cyc;
        dc_wr = 1; dc_wr_addr = 16'h0100; dc_wr_data = 16'h1357;
        dc_miss = 1; dc_miss_addr = 16'h5670;
        mem_q.push_back(mem_exp_t'{c0, 1'b1, 16'h0100, 16'h1357});
        push_fill(c0 + 1, 1, 16'h5670, 0);
        snap(c0, 0, 0, 1);
        tick();
        dc_wr = 0;
        wait_until(c0 + 14);
        dc_miss = 0;
        snap(c0 + 14, 0, 0, 0);
        repeat (5) tick();

        chk("mem_q drained", 64'(mem_q.size()), 64'd0);
        chk("fill_q drained", 64'(fill_q.size()), 64'd0);
        chk("snap_q drained", 64'(snap_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequences the single-ported main memory between the I-cache and D-cache miss paths and the D-cache write-through path. It grants one requester at a time and issues the eight word reads of a 16-byte block back to back. It steers returning words into the correct cache's data array and pulses that cache's tag-array write when the block is complete. It sits between both cache controllers and the memory module and is the sole driver of the memory address/enable/write pins.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width; block = 8 words
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (the codebase port name is kept despite the polarity)
- ic_miss / dc_miss  in  1  miss requests, held high until the matching tag write
- ic_miss_addr / dc_miss_addr  in  ADDR_W  missing address; bits [3:0] ignored
- dc_wr  in  1  write-through request, held until dc_wr_ack
- dc_wr_addr  in  ADDR_W, dc_wr_data  in  DATA_W  write address/data
- dc_wr_ack  out  1  one-cycle pulse, the cycle the write is on the memory pins
- ic_stall / dc_stall  out  1  requester waiting or being filled
- fill_data  out  DATA_W  mem_data_out, passed through
- fill_word  out  3  word index of the current return
- ic_fill_we / dc_fill_we  out  1  data-array write enables, at most one high
- ic_tag_we / dc_tag_we  out  1  one-cycle tag write pulse on the 8th return
- mem_en, mem_wr  out  1  memory enable / write
- mem_addr  out  ADDR_W, mem_data_in  out  DATA_W
- mem_data_out  in  DATA_W, mem_data_valid  in  1  read return

## Operation
- States: IDLE, FILL_I, FILL_D. The state register is held in IDLE during reset.
- Decision order in IDLE, one per cycle:
  - dc_wr: drive mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_data_in=dc_wr_data and pulse dc_wr_ack. Stay in IDLE. The write is combinational in that cycle.
  - Else, if exactly one miss is pending, go to its FILL state and latch its address[15:4] into base.
  - Else, if both misses are pending, serve the one not named by the last_fill bit (reset value = D, so I-cache wins first).
- FILL state, issue side:
  - The 3-bit issue_cnt starts at 0.
  - Each cycle while issue_cnt has not wrapped, drive mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0} and increment issue_cnt. Exactly 8 issues.
- FILL state, return side:
  - The 3-bit ret_cnt starts at 0.
  - On each mem_data_valid, drive fill_word=ret_cnt, raise the owning cache's fill_we, and increment ret_cnt.
  - On the valid with ret_cnt==7, pulse the owner's tag_we, update last_fill, and return to IDLE next cycle.
- Write/fill interaction: a dc_wr arriving during a fill waits until IDLE. Any pending write wins the first IDLE cycle after a fill.
- Stall outputs:
  - ic_stall = ic_miss, or state==FILL_I. dc_stall follows the same rule for D.
  - dc_stall is also high while dc_wr is pending without an ack.
- Boundary conditions:
  - Miss deasserted mid-fill: the fill still completes, and tag_we still fires.
  - mem_data_valid in IDLE: ignored, with no fill_we.
  - Reset mid-fill: state=IDLE, counters=0, last_fill=D. In-flight returns after reset are dropped.
- Reset values: every output is 0. mem_addr and mem_data_in are 0 whenever mem_en=0.

## Timing
- Cycle 0: miss seen in IDLE.
- Cycles 1–8: read issues.
- Returns: with the 4-cycle memory, returns arrive in cycles 5–12. The block tolerates any latency and any gaps, because it is driven only by mem_data_valid.
- Cycle 12: tag_we.
- Cycle 13: IDLE. The stall drops once the cache sees its hit.
- Minimum miss penalty at 4-cycle latency: 13 cycles.
- Write: single cycle; ack in the same cycle as the IDLE decision.
- Back-to-back fills: the second fill's first issue comes 2 cycles after the first fill's tag_we. One extra cycle is added if a write is pending.

## Structure
- Package cache_arb_pkg:
  - state enum {IDLE, FILL_I, FILL_D}
  - BLOCK_WORDS=8
  - WORD_IDX_W=3
  - owner encoding for last_fill
- Sub-module word_counter: a 3-bit counter with synchronous clear and enable, plus a wrap flag. Instantiated twice (issue and return).

## Test plan
- ic_miss, addr 0x1234; memory latency 4 → issues at 0x1230, 0x1232 … 0x123E in cycles 1–8; ic_fill_we with fill_word 0..7 in cycles 5–12; ic_tag_we pulse in cycle 12; ic_stall low when ic_miss drops.
- ic_miss and dc_miss raised in the same cycle after reset → I is filled first, then D; D's first issue comes 2 cycles after ic_tag_we; no dc_fill_we during the I fill.
- dc_wr (0x0040, 0xBEEF) raised while an I fill is mid-issue → no memory write until IDLE; then mem_wr=1 with that address/data for one cycle, dc_wr_ack pulse, and data unchanged.
- Returns with gaps (valid on alternate cycles) → still exactly 8 fill_we, ordered word indices 0..7, tag_we on the 8th.
- rst_n pulsed during cycle 6 of a fill → all outputs 0 in the next cycle; the remaining mem_data_valid pulses produce no fill_we or tag_we; a new miss afterwards fills normally.
- dc_wr held together with a pending dc_miss in IDLE → write acked first, fill starts the following cycle.
